// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decode-side fields, flush, the two writeback
// candidates used for forwarding, and everything the EX stage consumes.
// The stage itself connects through the slave modport.
interface id_ex_if;
  // Decode slot
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_shamt;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        flush;
  // Writeback candidates from later stages
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  // Stage outputs
  logic        stall_id;
  logic        ex_valid;
  logic [3:0]  alu_ctrl;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [31:0] ex_store_data;
  logic [15:0] stall_cnt;

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_shamt, id_alu_ctrl, id_alu_src, id_reg_write, id_mem_read,
           id_mem_write, flush, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    output stall_id, ex_valid, alu_ctrl, alu_shamt, alu_in1, alu_in2, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data, stall_cnt
  );

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_shamt, id_alu_ctrl, id_alu_src, id_reg_write, id_mem_read,
           id_mem_write, flush, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    input  stall_id, ex_valid, alu_ctrl, alu_shamt, alu_in1, alu_in2, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// operand forwarding and a saturating stall counter.
// Build option: define ID_EX_FORWARDING_EN to enable EX/MEM and MEM/WB
// forwarding; without it, operands come straight from the register file and
// the stage stalls on any in-flight producer still ahead of writeback.
module id_ex_stage (
  input  logic clk,
  input  logic reset,
  id_ex_if.slave bus
);

  // Stage register contents
  logic        ex_valid_q;
  logic        ex_reg_write_q;
  logic        ex_mem_read_q;
  logic        ex_mem_write_q;
  logic        ex_alu_src_q;
  logic [4:0]  ex_rd_q;
  logic [4:0]  ex_rs_q;
  logic [4:0]  ex_rt_q;
  logic [4:0]  ex_shamt_q;
  logic [3:0]  ex_alu_ctrl_q;
  logic [31:0] ex_rs_data_q;
  logic [31:0] ex_rt_data_q;
  logic [31:0] ex_imm_q;
  logic [15:0] stall_cnt_q;

  logic        id_reads_ex_rd;
  logic        load_use;
  logic        raw_stall;
  logic        stall;
  logic        bubble;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  // Load in EX whose destination the decode slot wants to read
  always_comb begin
    id_reads_ex_rd = (ex_rd_q != 5'd0) &&
                     ((ex_rd_q == bus.id_rs) || (ex_rd_q == bus.id_rt));
    load_use = ex_valid_q && ex_mem_read_q && bus.id_valid && id_reads_ex_rd;
  end

`ifdef ID_EX_FORWARDING_EN
  // Operand 1: youngest producer wins, register 0 never forwards
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
    fwd_rs = ex_rs_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == ex_rs_q))
      fwd_rs = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == ex_rs_q))
      fwd_rs = bus.memwb_data;
  end

  // Operand 2 / store data: same priority on rt
  always_comb begin
    fwd_rt = ex_rt_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == ex_rt_q))
      fwd_rt = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == ex_rt_q))
      fwd_rt = bus.memwb_data;
  end

  // Only loads need to stall when results can be forwarded
  always_comb raw_stall = load_use;
`else
  logic ex_hit;
  logic exmem_hit;
  logic unused_no_forwarding;

  // Without forwarding, wait until producers in EX and EX/MEM reach writeback
  always_comb begin
    ex_hit    = bus.id_valid && ex_valid_q && ex_reg_write_q && id_reads_ex_rd;
    exmem_hit = bus.id_valid && bus.exmem_reg_write && (bus.exmem_rd != 5'd0) &&
                ((bus.exmem_rd == bus.id_rs) || (bus.exmem_rd == bus.id_rt));
    raw_stall = load_use || ex_hit || exmem_hit;
    fwd_rs    = ex_rs_data_q;
    fwd_rt    = ex_rt_data_q;
  end

  // MEM/WB relies on the write-before-read register file in this build
  assign unused_no_forwarding = ^{bus.memwb_reg_write, bus.memwb_rd, bus.memwb_data,
                                  bus.exmem_result, ex_rs_q, ex_rt_q};
`endif

  // Flush overrides stall; nothing stalls while reset holds the stage
  always_comb begin
    stall  = raw_stall && !bus.flush && reset;
    bubble = bus.flush || stall || !bus.id_valid;
  end

  // Stage register: data fields always follow decode, controls become a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_alu_src_q   <= 1'b0;
      ex_rd_q        <= '0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_shamt_q     <= '0;
      ex_alu_ctrl_q  <= '0;
      ex_rs_data_q   <= '0;
      ex_rt_data_q   <= '0;
      ex_imm_q       <= '0;
      stall_cnt_q    <= '0;
    end else begin
      ex_rs_q      <= bus.id_rs;
      ex_rt_q      <= bus.id_rt;
      ex_rs_data_q <= bus.id_rs_data;
      ex_rt_data_q <= bus.id_rt_data;
      ex_imm_q     <= bus.id_imm;
      ex_shamt_q   <= bus.id_shamt;
      ex_alu_src_q <= bus.id_alu_src;
      if (bubble) begin
        ex_valid_q     <= 1'b0;
        ex_reg_write_q <= 1'b0;
        ex_mem_read_q  <= 1'b0;
        ex_mem_write_q <= 1'b0;
        ex_rd_q        <= '0;
        ex_alu_ctrl_q  <= '0;
      end else begin
        ex_valid_q     <= 1'b1;
        ex_reg_write_q <= bus.id_reg_write;
        ex_mem_read_q  <= bus.id_mem_read;
        ex_mem_write_q <= bus.id_mem_write;
        ex_rd_q        <= bus.id_rd;
        ex_alu_ctrl_q  <= bus.id_alu_ctrl;
      end
      if (stall && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  // Output drive
  assign bus.stall_id      = stall;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.alu_ctrl      = ex_alu_ctrl_q;
  assign bus.alu_shamt     = ex_shamt_q;
  assign bus.alu_in1       = fwd_rs;
  assign bus.alu_in2       = ex_alu_src_q ? ex_imm_q : fwd_rt;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_reg_write  = ex_reg_write_q;
  assign bus.ex_mem_read   = ex_mem_read_q;
  assign bus.ex_mem_write  = ex_mem_write_q;
  assign bus.ex_store_data = fwd_rt;
  assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed pipeline scenarios plus
// randomized traffic against a behavioural model of the stage contents.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic reset;
  id_ex_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // What the model believes sits in the EX stage
  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        src;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [3:0]  ctrl;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
  } ex_t;

  ex_t m;
  int unsigned m_cnt;

  function automatic bit reads_reg(logic [4:0] r);
    return (r != 5'd0) && ((r == bus.id_rs) || (r == bus.id_rt));
  endfunction

  function automatic bit exp_stall();
    if (reset !== 1'b1 || bus.flush || !bus.id_valid) return 1'b0;
    if (m.valid && m.mr && reads_reg(m.rd)) return 1'b1;
    if (!FWD && m.valid && m.rw && reads_reg(m.rd)) return 1'b1;
    if (!FWD && bus.exmem_reg_write && reads_reg(bus.exmem_rd)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_operand(logic [4:0] r, logic [31:0] rf_data);
    if (!FWD) return rf_data;
    if (bus.exmem_reg_write && bus.exmem_rd != 5'd0 && bus.exmem_rd == r) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd != 5'd0 && bus.memwb_rd == r) return bus.memwb_data;
    return rf_data;
  endfunction

  task automatic model_reset();
    m = '0;
    m_cnt = 0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge
  task automatic tick();
    bit s;
    s = exp_stall();
    @(posedge clk);
    if (bus.flush || s || !bus.id_valid) begin
      m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0;
      m.rd = '0; m.ctrl = '0;
    end else begin
      m.valid = 1'b1;
      m.rw = bus.id_reg_write; m.mr = bus.id_mem_read; m.mw = bus.id_mem_write;
      m.rd = bus.id_rd; m.ctrl = bus.id_alu_ctrl; m.src = bus.id_alu_src;
      m.rs = bus.id_rs; m.rt = bus.id_rt; m.shamt = bus.id_shamt;
      m.rsd = bus.id_rs_data; m.rtd = bus.id_rt_data; m.imm = bus.id_imm;
    end
    if (s && m_cnt < 65535) m_cnt++;
    #1;
  endtask

  task automatic drive_idle();
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0; bus.id_shamt = 0;
    bus.id_alu_ctrl = 0; bus.id_alu_src = 0; bus.id_reg_write = 0;
    bus.id_mem_read = 0; bus.id_mem_write = 0; bus.flush = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_data = 0;
  endtask

  task automatic set_id(input bit v, input logic [4:0] rs, rt, rd,
                        input logic [31:0] rsd, rtd, imm,
                        input bit src, rw, mr, mw);
    bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
    bus.id_alu_src = src; bus.id_reg_write = rw; bus.id_mem_read = mr;
    bus.id_mem_write = mw; bus.id_alu_ctrl = 4'h2; bus.id_shamt = 5'd0;
  endtask

  task automatic set_exmem(input bit rw, input logic [4:0] rd, input logic [31:0] res);
    bus.exmem_reg_write = rw; bus.exmem_rd = rd; bus.exmem_result = res;
  endtask

  task automatic set_memwb(input bit rw, input logic [4:0] rd, input logic [31:0] data);
    bus.memwb_reg_write = rw; bus.memwb_rd = rd; bus.memwb_data = data;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    model_reset();
    #2;
    checks++;
    if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
         bus.ex_rd, bus.alu_ctrl, bus.alu_shamt} !== 17'd0) begin
      errors++;
      $display("FAIL reset_controls: got %h expected 0", {bus.ex_valid, bus.ex_reg_write,
               bus.ex_mem_read, bus.ex_mem_write, bus.ex_rd, bus.alu_ctrl, bus.alu_shamt});
    end
    checks++;
    if ({bus.alu_in1, bus.alu_in2, bus.ex_store_data} !== 96'd0) begin
      errors++;
      $display("FAIL reset_operands: got %h %h %h expected 0", bus.alu_in1, bus.alu_in2, bus.ex_store_data);
    end
    checks++;
    if (bus.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_stall_cnt: got %h expected 0", bus.stall_cnt);
    end
    #10 reset = 1'b1;
    // First instruction after release is captured normally, no stall on the bubble
    set_id(1, 5'd1, 5'd2, 5'd9, 32'h11, 32'h22, 32'h0, 0, 1, 0, 0);
    #2;
    checks++;
    if (bus.stall_id !== 1'b0) begin
      errors++; $display("FAIL reset_bubble_stall: got %b expected 0", bus.stall_id);
    end
    tick();
    drive_idle();
    #2;
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd9) begin
      errors++; $display("FAIL first_capture: got valid=%b rd=%0d expected valid=1 rd=9", bus.ex_valid, bus.ex_rd);
    end
    checks++;
    if (bus.alu_in1 !== 32'h11 || bus.alu_in2 !== 32'h22) begin
      errors++; $display("FAIL first_operands: got %h %h expected 11 22", bus.alu_in1, bus.alu_in2);
    end
  endtask

  // add r3 followed by sub r5,r3,r4
  task automatic test_back_to_back();
    int unsigned cnt0;
    drive_idle(); tick();
    set_id(1, 5'd1, 5'd2, 5'd3, 32'h8, 32'h8, 32'h0, 0, 1, 0, 0);
    #2;
    checks++;
    if (bus.stall_id !== 1'b0) begin
      errors++; $display("FAIL b2b_add_stall: got %b expected 0", bus.stall_id);
    end
    tick();
    cnt0 = m_cnt;
    set_id(1, 5'd3, 5'd4, 5'd5, 32'h77, 32'h5, 32'h0, 0, 1, 0, 0);
    #2;
    checks++;
    if (bus.stall_id !== !FWD) begin
      errors++; $display("FAIL b2b_sub_stall1: got %b expected %b", bus.stall_id, !FWD);
    end
    tick();
`ifdef ID_EX_FORWARDING_EN
    bus.id_valid = 0;
    set_exmem(1, 5'd3, 32'h10);
    #2;
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.alu_in1 !== 32'h10) begin
      errors++; $display("FAIL b2b_forward: got valid=%b in1=%h expected 1 00000010", bus.ex_valid, bus.alu_in1);
    end
`else
    set_exmem(1, 5'd3, 32'h10);
    #2;
    checks++;
    if (bus.stall_id !== 1'b1 || bus.ex_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_sub_stall2: got stall=%b valid=%b expected 1 0", bus.stall_id, bus.ex_valid);
    end
    tick();
    set_exmem(0, 5'd0, 32'h0);
    set_memwb(1, 5'd3, 32'h10);
    #2;
    checks++;
    if (bus.stall_id !== 1'b0) begin
      errors++; $display("FAIL b2b_release: got %b expected 0", bus.stall_id);
    end
    tick();
    bus.id_valid = 0;
    set_memwb(0, 5'd0, 32'h0);
    #2;
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.alu_in1 !== 32'h77) begin
      errors++; $display("FAIL b2b_rf_data: got valid=%b in1=%h expected 1 00000077", bus.ex_valid, bus.alu_in1);
    end
`endif
    checks++;
    if (bus.stall_cnt !== 16'(cnt0 + (FWD ? 0 : 2))) begin
      errors++; $display("FAIL b2b_stall_cnt: got %0d expected %0d", bus.stall_cnt, cnt0 + (FWD ? 0 : 2));
    end
    drive_idle(); tick();
  endtask

  task automatic test_double_match();
    drive_idle(); tick();
    set_id(1, 5'd7, 5'd9, 5'd11, 32'h55, 32'h66, 32'h1234, 1, 1, 0, 0);
    #2; tick();
    drive_idle();
    set_exmem(1, 5'd7, 32'hA);
    set_memwb(1, 5'd7, 32'hB);
    #2;
    checks++;
    if (bus.alu_in1 !== (FWD ? 32'hA : 32'h55)) begin
      errors++; $display("FAIL dm_exmem_wins: got %h expected %h", bus.alu_in1, FWD ? 32'hA : 32'h55);
    end
    checks++;
    if (bus.alu_in2 !== 32'h1234) begin
      errors++; $display("FAIL dm_imm_operand: got %h expected 00001234", bus.alu_in2);
    end
    set_exmem(0, 5'd7, 32'hA);
    #1;
    checks++;
    if (bus.alu_in1 !== (FWD ? 32'hB : 32'h55)) begin
      errors++; $display("FAIL dm_memwb: got %h expected %h", bus.alu_in1, FWD ? 32'hB : 32'h55);
    end
    set_exmem(1, 5'd9, 32'hC);
    set_memwb(0, 5'd0, 32'h0);
    #1;
    checks++;
    if (bus.ex_store_data !== (FWD ? 32'hC : 32'h66) || bus.alu_in2 !== 32'h1234) begin
      errors++; $display("FAIL dm_store_fwd: got %h/%h expected %h/00001234",
                         bus.ex_store_data, bus.alu_in2, FWD ? 32'hC : 32'h66);
    end
    tick();
    set_id(1, 5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h0, 0, 1, 0, 0);
    set_exmem(0, 5'd0, 32'h0);
    #2; tick();
    drive_idle();
    set_exmem(1, 5'd0, 32'hFF);
    set_memwb(1, 5'd0, 32'hFF);
    #2;
    checks++;
    if (bus.alu_in1 !== 32'h0 || bus.alu_in2 !== 32'h0) begin
      errors++; $display("FAIL dm_r0_no_fwd: got %h %h expected 0 0", bus.alu_in1, bus.alu_in2);
    end
    drive_idle(); tick();
  endtask

  // lw r2 followed by a reader of r2
  task automatic test_load_use();
    int unsigned cnt0;
    drive_idle(); tick();
    set_id(1, 5'd1, 5'd0, 5'd2, 32'h100, 32'h0, 32'h4, 1, 1, 1, 0);
    #2; tick();
    set_id(1, 5'd2, 5'd6, 5'd10, 32'h99, 32'h5, 32'h0, 0, 1, 0, 0);
    #2;
    checks++;
    if (bus.stall_id !== 1'b1) begin
      errors++; $display("FAIL lu_stall: got %b expected 1", bus.stall_id);
    end
    cnt0 = m_cnt;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.stall_cnt !== 16'(cnt0 + 1)) begin
      errors++; $display("FAIL lu_bubble: got valid=%b cnt=%0d expected 0 %0d", bus.ex_valid, bus.stall_cnt, cnt0 + 1);
    end
    set_exmem(1, 5'd2, 32'h1000);
    #2;
    checks++;
    if (bus.stall_id !== !FWD) begin
      errors++; $display("FAIL lu_second_cycle: got %b expected %b", bus.stall_id, !FWD);
    end
    tick();
`ifdef ID_EX_FORWARDING_EN
    bus.id_valid = 0;
    set_exmem(0, 5'd0, 32'h0);
    set_memwb(1, 5'd2, 32'hBEEF);
    #2;
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.alu_in1 !== 32'hBEEF) begin
      errors++; $display("FAIL lu_memwb_fwd: got valid=%b in1=%h expected 1 0000beef", bus.ex_valid, bus.alu_in1);
    end
`else
    set_exmem(0, 5'd0, 32'h0);
    set_memwb(1, 5'd2, 32'hBEEF);
    #2; tick();
    bus.id_valid = 0;
    set_memwb(0, 5'd0, 32'h0);
    #2;
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.alu_in1 !== 32'h99) begin
      errors++; $display("FAIL lu_rf_data: got valid=%b in1=%h expected 1 00000099", bus.ex_valid, bus.alu_in1);
    end
`endif
    drive_idle(); tick();
  endtask

  task automatic test_flush_hazard();
    int unsigned cnt0;
    drive_idle(); tick();
    set_id(1, 5'd1, 5'd0, 5'd2, 32'h100, 32'h0, 32'h4, 1, 1, 1, 0);
    #2; tick();
    set_id(1, 5'd2, 5'd6, 5'd10, 32'h99, 32'h5, 32'h0, 0, 1, 0, 0);
    bus.flush = 1'b1;
    #2;
    checks++;
    if (bus.stall_id !== 1'b0) begin
      errors++; $display("FAIL flush_stall: got %b expected 0", bus.stall_id);
    end
    cnt0 = m_cnt;
    tick();
    drive_idle();
    #2;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_rd !== 5'd0 ||
        bus.stall_cnt !== 16'(cnt0)) begin
      errors++; $display("FAIL flush_bubble: got valid=%b rw=%b rd=%0d cnt=%0d expected 0 0 0 %0d",
                         bus.ex_valid, bus.ex_reg_write, bus.ex_rd, bus.stall_cnt, cnt0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.id_valid = ($urandom_range(0, 9) < 8);
      bus.id_rs = 5'($urandom_range(0, 3));
      bus.id_rt = 5'($urandom_range(0, 3));
      bus.id_rd = 5'($urandom_range(0, 3));
      bus.id_rs_data = $urandom; bus.id_rt_data = $urandom; bus.id_imm = $urandom;
      bus.id_shamt = 5'($urandom); bus.id_alu_ctrl = 4'($urandom);
      bus.id_alu_src = 1'($urandom); bus.id_reg_write = 1'($urandom);
      bus.id_mem_read = ($urandom_range(0, 3) == 0); bus.id_mem_write = 1'($urandom);
      bus.flush = ($urandom_range(0, 9) == 0);
      set_exmem(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      set_memwb(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      #2;
      checks++;
      if (bus.stall_id !== exp_stall()) begin
        errors++; $display("FAIL rand_stall @%0d: got %b expected %b", i, bus.stall_id, exp_stall());
      end
      checks++;
      if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_rd, bus.alu_ctrl} !==
          {m.valid, m.rw, m.mr, m.mw, m.rd, m.ctrl}) begin
        errors++; $display("FAIL rand_controls @%0d: got %h expected %h", i,
                           {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_rd, bus.alu_ctrl},
                           {m.valid, m.rw, m.mr, m.mw, m.rd, m.ctrl});
      end
      checks++;
      if (bus.stall_cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL rand_stall_cnt @%0d: got %0d expected %0d", i, bus.stall_cnt, m_cnt);
      end
      if (m.valid) begin
        checks++;
        if (bus.alu_in1 !== exp_operand(m.rs, m.rsd)) begin
          errors++; $display("FAIL rand_alu_in1 @%0d: got %h expected %h", i, bus.alu_in1, exp_operand(m.rs, m.rsd));
        end
        checks++;
        if (bus.alu_in2 !== (m.src ? m.imm : exp_operand(m.rt, m.rtd))) begin
          errors++; $display("FAIL rand_alu_in2 @%0d: got %h expected %h", i, bus.alu_in2,
                             m.src ? m.imm : exp_operand(m.rt, m.rtd));
        end
        checks++;
        if (bus.ex_store_data !== exp_operand(m.rt, m.rtd) || bus.alu_shamt !== m.shamt) begin
          errors++; $display("FAIL rand_store_shamt @%0d: got %h/%0d expected %h/%0d", i,
                             bus.ex_store_data, bus.alu_shamt, exp_operand(m.rt, m.rtd), m.shamt);
        end
      end
      tick();
    end
    drive_idle(); tick();
  endtask

  task automatic test_saturation_and_reset();
    drive_idle(); tick();
`ifdef ID_EX_FORWARDING_EN
    // Stalls can only alternate with loads here, so check counting, not the ceiling
    for (int i = 0; i < 300; i++) begin
      set_id(1, 5'd1, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 1, 1, 1, 0);
      #2; tick();
      set_id(1, 5'd3, 5'd4, 5'd8, 32'h0, 32'h0, 32'h0, 0, 1, 0, 0);
      if (i != 299) begin
        #2; tick();
      end
    end
    #2;
    checks++;
    if (bus.stall_cnt !== 16'(m_cnt)) begin
      errors++; $display("FAIL sat_count: got %0d expected %0d", bus.stall_cnt, m_cnt);
    end
`else
    set_id(1, 5'd3, 5'd4, 5'd8, 32'h1, 32'h2, 32'h0, 0, 1, 0, 0);
    set_exmem(1, 5'd3, 32'h5);
    for (int i = 0; i < 65540; i++) tick();
    #2;
    checks++;
    if (bus.stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_ceiling: got %h expected ffff", bus.stall_cnt);
    end
`endif
    checks++;
    if (bus.stall_id !== 1'b1) begin
      errors++; $display("FAIL sat_still_stalling: got %b expected 1", bus.stall_id);
    end
    // Reset dropped mid-stall, away from any clock edge
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.stall_id, bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
         bus.ex_rd, bus.alu_ctrl, bus.alu_shamt, bus.stall_cnt} !== 34'd0) begin
      errors++; $display("FAIL async_reset_controls: got %h expected 0", {bus.stall_id, bus.ex_valid,
               bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_rd, bus.alu_ctrl,
               bus.alu_shamt, bus.stall_cnt});
    end
    checks++;
    if ({bus.alu_in1, bus.alu_in2, bus.ex_store_data} !== 96'd0) begin
      errors++; $display("FAIL async_reset_operands: got %h %h %h expected 0",
                         bus.alu_in1, bus.alu_in2, bus.ex_store_data);
    end
    #2 reset = 1'b1;
    drive_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_double_match();
    test_load_use();
    test_flush_hazard();
    test_random();
    test_saturation_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
